// File: rtl/alu_op_decode_stage.sv
// -----------------------------------------------------------------------------
// alu_op_decode_stage
//
// Purpose:
//   Decode-to-execute pipeline stage for an RV64I(+mul) core. Decodes one
//   32-bit instruction into the one-hot ALUOp, the W-form flag, the ALU operand
//   selects and the sign-extended 64-bit immediate. All of this is held in a
//   one-entry valid/ready register stage.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              drops the held entry and any entry offered this cycle
//   in_valid/in_ready  upstream handshake; in_ready = !out_valid | out_ready
//   in_inst, in_pc     instruction word and its pc
//   out_valid/out_ready downstream handshake
//   out_alu_op         one-hot ALUOp (all zero for illegal entries)
//   out_is32           W-form operation (OP-32 / OP-IMM-32)
//   out_a_sel          X source: 0 rs1, 1 pc, 2 zero
//   out_b_sel          Y source: 0 rs2, 1 imm, 2 constant 4
//   out_imm            sign-extended immediate (shift forms: zero-extended shamt)
//   out_rd/rs1/rs2     register indices taken straight from the instruction
//   out_reg_write      rd write enable (never set for rd == x0)
//   out_illegal        unsupported encoding; the entry still flows downstream
//
// Handshake:
//   A transfer happens on a rising edge where valid and ready are both high.
//   valid is never withdrawn by the producer until the transfer, and the
//   registered payload never changes while out_valid=1 and out_ready=0.
//   in_ready is combinational from out_valid/out_ready only, so a consume and
//   an accept can share one edge (full throughput). flush overrides both.
// -----------------------------------------------------------------------------
module alu_op_decode_stage #(
    parameter int XLEN = 64,
    parameter int OPW  = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OPW-1:0]  out_alu_op,
    output logic            out_is32,
    output logic [1:0]      out_a_sel,
    output logic [1:0]      out_b_sel,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_reg_write,
    output logic            out_illegal
);

    // One-hot ALUOp encodings; bit positions match the ALU input.
    localparam logic [OPW-1:0] ALU_ADD  = OPW'(1) << 0;
    localparam logic [OPW-1:0] ALU_SUB  = OPW'(1) << 1;
    localparam logic [OPW-1:0] ALU_AND  = OPW'(1) << 2;
    localparam logic [OPW-1:0] ALU_OR   = OPW'(1) << 3;
    localparam logic [OPW-1:0] ALU_XOR  = OPW'(1) << 4;
    localparam logic [OPW-1:0] ALU_SLL  = OPW'(1) << 5;
    localparam logic [OPW-1:0] ALU_SRL  = OPW'(1) << 6;
    localparam logic [OPW-1:0] ALU_SRA  = OPW'(1) << 7;
    localparam logic [OPW-1:0] ALU_MUL  = OPW'(1) << 8;
    localparam logic [OPW-1:0] ALU_SLT  = OPW'(1) << 12;
    localparam logic [OPW-1:0] ALU_SLTU = OPW'(1) << 13;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;
    localparam logic [1:0] B_RS2  = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;
    localparam logic [1:0] B_FOUR = 2'd2;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];

    // The pc only travels with the instruction for the ALU's benefit upstream;
    // this stage selects it via out_a_sel and does not carry it.
    logic pc_unused;
    assign pc_unused = ^in_pc;

    // Immediate formats, all sign-extended from inst[31].
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh6, imm_sh5;

    assign imm_i   = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
    assign imm_s   = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b   = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                      in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u   = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
    assign imm_j   = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                      in_inst[20], in_inst[30:21], 1'b0};
    // Shift-immediate forms carry only the shift amount, not the funct bits.
    assign imm_sh6 = {{(XLEN-6){1'b0}}, in_inst[25:20]};
    assign imm_sh5 = {{(XLEN-5){1'b0}}, in_inst[24:20]};

    // Shared funct3 map of OP and OP-IMM; f3=5 returns srl and is refined
    // by the caller when the arithmetic-shift form is selected.
    function automatic logic [OPW-1:0] base_op(input logic [2:0] fn3);
        logic [OPW-1:0] op;
        case (fn3)
            3'd0:    op = ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [OPW-1:0]  d_alu_op;
    logic            d_is32;
    logic [1:0]      d_a_sel;
    logic [1:0]      d_b_sel;
    logic [XLEN-1:0] d_imm;
    logic            d_has_rd;
    logic            d_illegal;
    logic            d_reg_write;

    always_comb begin
        d_alu_op  = '0;
        d_is32    = 1'b0;
        d_a_sel   = A_RS1;
        d_b_sel   = B_RS2;
        d_imm     = '0;
        d_has_rd  = 1'b0;
        d_illegal = 1'b0;

        case (opcode)
            OPC_OP: begin
                d_has_rd = 1'b1;
                if (f7 == 7'h00)                    d_alu_op = base_op(f3);
                else if (f7 == 7'h20 && f3 == 3'd0) d_alu_op = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) d_alu_op = ALU_SRA;
                else if (f7 == 7'h01 && f3 == 3'd0) d_alu_op = ALU_MUL;
                else                                d_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                d_has_rd = 1'b1;
                d_b_sel  = B_IMM;
                d_imm    = imm_i;
                d_alu_op = base_op(f3);
                if (f3 == 3'd1) begin
                    d_imm = imm_sh6;
                    if (in_inst[31:26] != 6'b000000) d_illegal = 1'b1;
                end else if (f3 == 3'd5) begin
                    d_imm = imm_sh6;
                    if (in_inst[31:26] == 6'b010000)      d_alu_op  = ALU_SRA;
                    else if (in_inst[31:26] != 6'b000000) d_illegal = 1'b1;
                end
            end
            OPC_OP_32: begin
                d_has_rd = 1'b1;
                d_is32   = 1'b1;
                if (f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5))
                    d_alu_op = base_op(f3);
                else if (f7 == 7'h20 && f3 == 3'd0) d_alu_op = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) d_alu_op = ALU_SRA;
                else if (f7 == 7'h01 && f3 == 3'd0) d_alu_op = ALU_MUL;
                else                                d_illegal = 1'b1;
            end
            OPC_OP_IMM_32: begin
                d_has_rd = 1'b1;
                d_is32   = 1'b1;
                d_b_sel  = B_IMM;
                d_imm    = imm_sh5;
                // Checking all of inst[31:25] also rejects inst[25]=1 (shamt >= 32).
                if (f3 == 3'd0) begin
                    d_alu_op = ALU_ADD;
                    d_imm    = imm_i;
                end else if (f3 == 3'd1 && f7 == 7'h00) d_alu_op = ALU_SLL;
                else if (f3 == 3'd5 && f7 == 7'h00)     d_alu_op = ALU_SRL;
                else if (f3 == 3'd5 && f7 == 7'h20)     d_alu_op = ALU_SRA;
                else                                    d_illegal = 1'b1;
            end
            OPC_LUI: begin
                d_has_rd = 1'b1;
                d_alu_op = ALU_ADD;
                d_a_sel  = A_ZERO;
                d_b_sel  = B_IMM;
                d_imm    = imm_u;
            end
            OPC_AUIPC: begin
                d_has_rd = 1'b1;
                d_alu_op = ALU_ADD;
                d_a_sel  = A_PC;
                d_b_sel  = B_IMM;
                d_imm    = imm_u;
            end
            OPC_LOAD: begin
                d_has_rd = 1'b1;
                d_alu_op = ALU_ADD;
                d_b_sel  = B_IMM;
                d_imm    = imm_i;
            end
            OPC_STORE: begin
                d_alu_op = ALU_ADD;
                d_b_sel  = B_IMM;
                d_imm    = imm_s;
            end
            // Jumps use the ALU for the link value pc+4; the target offset
            // still travels in out_imm for the branch unit.
            OPC_JAL: begin
                d_has_rd = 1'b1;
                d_alu_op = ALU_ADD;
                d_a_sel  = A_PC;
                d_b_sel  = B_FOUR;
                d_imm    = imm_j;
            end
            OPC_JALR: begin
                d_has_rd = 1'b1;
                d_alu_op = ALU_ADD;
                d_a_sel  = A_PC;
                d_b_sel  = B_FOUR;
                d_imm    = imm_i;
            end
            OPC_BRANCH: begin
                d_imm = imm_b;
                case (f3)
                    3'd0, 3'd1: d_alu_op  = ALU_SUB;
                    3'd4, 3'd5: d_alu_op  = ALU_SLT;
                    3'd6, 3'd7: d_alu_op  = ALU_SLTU;
                    default:    d_illegal = 1'b1;
                endcase
            end
            default: d_illegal = 1'b1;
        endcase

        // Illegal entries carry a clean, inert payload downstream.
        if (d_illegal) begin
            d_alu_op = '0;
            d_is32   = 1'b0;
            d_a_sel  = A_RS1;
            d_b_sel  = B_RS2;
            d_imm    = '0;
            d_has_rd = 1'b0;
        end
    end

    assign d_reg_write = d_has_rd && (in_inst[11:7] != 5'd0);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_alu_op    <= '0;
            out_is32      <= 1'b0;
            out_a_sel     <= 2'd0;
            out_b_sel     <= 2'd0;
            out_imm       <= '0;
            out_rd        <= 5'd0;
            out_rs1       <= 5'd0;
            out_rs2       <= 5'd0;
            out_reg_write <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (flush) begin
            // Payload holds; only the valid bit is killed.
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid     <= 1'b1;
            out_alu_op    <= d_alu_op;
            out_is32      <= d_is32;
            out_a_sel     <= d_a_sel;
            out_b_sel     <= d_b_sel;
            out_imm       <= d_imm;
            out_rd        <= in_inst[11:7];
            out_rs1       <= in_inst[19:15];
            out_rs2       <= in_inst[24:20];
            out_reg_write <= d_reg_write;
            out_illegal   <= d_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_op_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_op_decode_stage
//
// Directed bench for alu_op_decode_stage: a decode table with hand-computed
// expectations, backpressure, flush, a random-ready stream tracked by an
// expected queue, and an asynchronous reset while an entry is held.
// -----------------------------------------------------------------------------
module tb_alu_op_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_alu_op;
    logic        out_is32;
    logic [1:0]  out_a_sel;
    logic [1:0]  out_b_sel;
    logic [63:0] out_imm;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic        out_reg_write;
    logic        out_illegal;

    int n_checks = 0;
    int n_errors = 0;

    logic [14:0] exp_q[$];

    typedef struct {
        logic [31:0] inst;
        logic [14:0] alu;
        logic        is32;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [63:0] imm;
        logic        rw;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    alu_op_decode_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_inst       (in_inst),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_op    (out_alu_op),
        .out_is32      (out_is32),
        .out_a_sel     (out_a_sel),
        .out_b_sel     (out_b_sel),
        .out_imm       (out_imm),
        .out_rd        (out_rd),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_reg_write (out_reg_write),
        .out_illegal   (out_illegal)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] inst, input logic rdy, input logic fl);
        in_valid  = v;
        in_inst   = inst;
        in_pc     = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 4;
        out_ready = rdy;
        flush     = fl;
    endtask

    // Advance one edge; leaves time just after the edge, away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_add(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic add_vec(input logic [31:0] inst, input logic [14:0] alu, input logic is32,
                           input logic [1:0] a, input logic [1:0] b, input logic [63:0] imm,
                           input logic rw, input logic ill);
        vec_t v;
        v.inst = inst; v.alu = alu; v.is32 = is32; v.a = a; v.b = b;
        v.imm = imm; v.rw = rw; v.ill = ill;
        vecs.push_back(v);
    endtask

    task automatic build_table();
        //      inst          alu       is32  a     b     imm                     rw    ill
        add_vec(32'h002081B3, 15'h0001, 1'b0, 2'd0, 2'd0, 64'h0,                  1'b1, 1'b0);
        add_vec(32'h402081B3, 15'h0002, 1'b0, 2'd0, 2'd0, 64'h0,                  1'b1, 1'b0);
        add_vec(32'h002091B3, 15'h0020, 1'b0, 2'd0, 2'd0, 64'h0,                  1'b1, 1'b0);
        add_vec(32'h0020A1B3, 15'h1000, 1'b0, 2'd0, 2'd0, 64'h0,                  1'b1, 1'b0);
        add_vec(32'h0020B1B3, 15'h2000, 1'b0, 2'd0, 2'd0, 64'h0,                  1'b1, 1'b0);
        add_vec(32'h0020C1B3, 15'h0010, 1'b0, 2'd0, 2'd0, 64'h0,                  1'b1, 1'b0);
        add_vec(32'h0020D1B3, 15'h0040, 1'b0, 2'd0, 2'd0, 64'h0,                  1'b1, 1'b0);
        add_vec(32'h4020D1B3, 15'h0080, 1'b0, 2'd0, 2'd0, 64'h0,                  1'b1, 1'b0);
        add_vec(32'h0020E1B3, 15'h0008, 1'b0, 2'd0, 2'd0, 64'h0,                  1'b1, 1'b0);
        add_vec(32'h0020F1B3, 15'h0004, 1'b0, 2'd0, 2'd0, 64'h0,                  1'b1, 1'b0);
        add_vec(32'h022081B3, 15'h0100, 1'b0, 2'd0, 2'd0, 64'h0,                  1'b1, 1'b0);
        add_vec(32'h4033529B, 15'h0080, 1'b1, 2'd0, 2'd1, 64'h3,                  1'b1, 1'b0);
        add_vec(32'hFFF00093, 15'h0001, 1'b0, 2'd0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        add_vec(32'h03F09193, 15'h0020, 1'b0, 2'd0, 2'd1, 64'h3F,                 1'b1, 1'b0);
        add_vec(32'h43F0D193, 15'h0080, 1'b0, 2'd0, 2'd1, 64'h3F,                 1'b1, 1'b0);
        add_vec(32'hFFF0A193, 15'h1000, 1'b0, 2'd0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        add_vec(32'h0FF0F193, 15'h0004, 1'b0, 2'd0, 2'd1, 64'hFF,                 1'b1, 1'b0);
        add_vec(32'h00000013, 15'h0001, 1'b0, 2'd0, 2'd1, 64'h0,                  1'b0, 1'b0);
        add_vec(32'h20009093, 15'h0000, 1'b0, 2'd0, 2'd0, 64'h0,                  1'b0, 1'b1);
        add_vec(32'h022081BB, 15'h0100, 1'b1, 2'd0, 2'd0, 64'h0,                  1'b1, 1'b0);
        add_vec(32'h402081BB, 15'h0002, 1'b1, 2'd0, 2'd0, 64'h0,                  1'b1, 1'b0);
        add_vec(32'h0020A1BB, 15'h0000, 1'b0, 2'd0, 2'd0, 64'h0,                  1'b0, 1'b1);
        add_vec(32'h01F0919B, 15'h0020, 1'b1, 2'd0, 2'd1, 64'h1F,                 1'b1, 1'b0);
        add_vec(32'h0200919B, 15'h0000, 1'b0, 2'd0, 2'd0, 64'h0,                  1'b0, 1'b1);
        add_vec(32'hFFF0819B, 15'h0001, 1'b1, 2'd0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        add_vec(32'h123452B7, 15'h0001, 1'b0, 2'd2, 2'd1, 64'h1234_5000,          1'b1, 1'b0);
        add_vec(32'h800002B7, 15'h0001, 1'b0, 2'd2, 2'd1, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0);
        add_vec(32'h00001097, 15'h0001, 1'b0, 2'd1, 2'd1, 64'h1000,               1'b1, 1'b0);
        add_vec(32'h008000EF, 15'h0001, 1'b0, 2'd1, 2'd2, 64'h8,                  1'b1, 1'b0);
        add_vec(32'h00008067, 15'h0001, 1'b0, 2'd1, 2'd2, 64'h0,                  1'b0, 1'b0);
        add_vec(32'hFE209EE3, 15'h0002, 1'b0, 2'd0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
        add_vec(32'hFE20EEE3, 15'h2000, 1'b0, 2'd0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
        add_vec(32'hFE20AEE3, 15'h0000, 1'b0, 2'd0, 2'd0, 64'h0,                  1'b0, 1'b1);
        add_vec(32'h0020A423, 15'h0001, 1'b0, 2'd0, 2'd1, 64'h8,                  1'b0, 1'b0);
        add_vec(32'hFF813183, 15'h0001, 1'b0, 2'd0, 2'd1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b0);
        add_vec(32'h00000000, 15'h0000, 1'b0, 2'd0, 2'd0, 64'h0,                  1'b0, 1'b1);
        add_vec(32'h0220A1B3, 15'h0000, 1'b0, 2'd0, 2'd0, 64'h0,                  1'b0, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        build_table();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'h0);
        check("reset_alu_op", 64'(out_alu_op), 64'h0);
        check("reset_imm", out_imm, 64'h0);
        check("reset_in_ready", 64'(in_ready), 64'h1);
        rst_n = 1'b1;
        tick();

        // add x3,x1,x2: full field check, one-cycle latency
        drive(1'b1, 32'h002081B3, 1'b1, 1'b0);
        tick();
        check("add_valid", 64'(out_valid), 64'h1);
        check("add_rd", 64'(out_rd), 64'd3);
        check("add_rs1", 64'(out_rs1), 64'd1);
        check("add_rs2", 64'(out_rs2), 64'd2);

        // decode table, one entry per cycle with out_ready=1
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].inst, 1'b1, 1'b0);
            tick();
            check($sformatf("v%0d_valid", i), 64'(out_valid), 64'h1);
            check($sformatf("v%0d_alu_op", i), 64'(out_alu_op), 64'(vecs[i].alu));
            check($sformatf("v%0d_is32", i), 64'(out_is32), 64'(vecs[i].is32));
            check($sformatf("v%0d_a_sel", i), 64'(out_a_sel), 64'(vecs[i].a));
            check($sformatf("v%0d_b_sel", i), 64'(out_b_sel), 64'(vecs[i].b));
            check($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
            check($sformatf("v%0d_reg_write", i), 64'(out_reg_write), 64'(vecs[i].rw));
            check($sformatf("v%0d_illegal", i), 64'(out_illegal), 64'(vecs[i].ill));
        end

        // drain
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        check("drain_valid", 64'(out_valid), 64'h0);

        // backpressure: hold A for three cycles while B waits
        drive(1'b1, mk_add(5'd7, 5'd1, 5'd2), 1'b0, 1'b0);
        tick();
        check("bp_load_valid", 64'(out_valid), 64'h1);
        check("bp_load_rd", 64'(out_rd), 64'd7);
        drive(1'b1, mk_add(5'd9, 5'd4, 5'd5), 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp_in_ready_%0d", c), 64'(in_ready), 64'h0);
            tick();
            check($sformatf("bp_hold_valid_%0d", c), 64'(out_valid), 64'h1);
            check($sformatf("bp_hold_rd_%0d", c), 64'(out_rd), 64'd7);
            check($sformatf("bp_hold_rs1_%0d", c), 64'(out_rs1), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'h1);
        tick();
        check("bp_next_valid", 64'(out_valid), 64'h1);
        check("bp_next_rd", 64'(out_rd), 64'd9);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        check("bp_no_dup_valid", 64'(out_valid), 64'h0);

        // flush while an entry is held and another is being accepted
        drive(1'b1, mk_add(5'd7, 5'd1, 5'd2), 1'b1, 1'b0);
        tick();
        check("fl_pre_valid", 64'(out_valid), 64'h1);
        drive(1'b1, mk_add(5'd9, 5'd4, 5'd5), 1'b1, 1'b1);
        tick();
        check("fl_valid", 64'(out_valid), 64'h0);
        check("fl_payload_hold_rd", 64'(out_rd), 64'd7);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        check("fl_dropped_valid", 64'(out_valid), 64'h0);

        // flush with out_ready=0 still clears
        drive(1'b1, mk_add(5'd11, 5'd1, 5'd2), 1'b0, 1'b0);
        tick();
        check("fl2_pre_valid", 64'(out_valid), 64'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        check("fl2_valid", 64'(out_valid), 64'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();

        // random-ready stream: every accepted entry leaves once, in order
        begin
            int idx;
            int cycles;
            logic [14:0] key;
            logic [14:0] got;
            idx = 0;
            cycles = 0;
            while ((idx < 12 || exp_q.size() > 0) && cycles < 300) begin
                drive(idx < 12, mk_add(5'(idx + 1), 5'(idx + 5), 5'(idx + 9)),
                      1'($urandom_range(0, 1)), 1'b0);
                #1;
                check("st_in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
                if (out_valid && out_ready) begin
                    got = {out_rd, out_rs1, out_rs2};
                    if (exp_q.size() == 0) begin
                        check("st_unexpected_entry", 64'(got), 64'h7FFF_0000);
                    end else begin
                        key = exp_q.pop_front();
                        check("st_order", 64'(got), 64'(key));
                        check("st_alu_op", 64'(out_alu_op), 64'h1);
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back({5'(idx + 1), 5'(idx + 5), 5'(idx + 9)});
                    idx++;
                end
                tick();
                cycles++;
            end
            check("st_all_sent", 64'(idx), 64'd12);
            check("st_queue_empty", 64'(exp_q.size()), 64'd0);
        end

        // async reset while an entry is held, no clock edge in between
        drive(1'b1, 32'h002081B3, 1'b0, 1'b0);
        tick();
        check("rst_pre_valid", 64'(out_valid), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_alu_op", 64'(out_alu_op), 64'h0);
        check("rst_rd", 64'(out_rd), 64'h0);
        check("rst_rs1", 64'(out_rs1), 64'h0);
        check("rst_reg_write", 64'(out_reg_write), 64'h0);
        check("rst_sels", 64'({out_a_sel, out_b_sel, out_is32, out_illegal}), 64'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", 64'(out_valid), 64'h0);
        check("post_rst_in_ready", 64'(in_ready), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
